// File: rtl/serial_add_ctrl_if.sv
// Operand request / result handshake bundle for the bit-serial adder.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, op_a, op_b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, op_a, op_b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell (two half adders + OR) stepped over
// WIDTH cycles, with valid/ready on both the operand and result sides.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus,
    output logic              busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             s1, c1, s, c2, carry_next;

    half_adder u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(s1), .c(c1));
    half_adder u_ha1 (.a(s1),      .b(carry),   .s(s),  .c(c2));

    assign carry_next = c1 | c2;
    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign acc_next   = (acc >> 1) | (WIDTH'(s) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
            busy          <= 1'b0;
            a_sh          <= '0;
            b_sh          <= '0;
            acc           <= '0;
            cnt           <= '0;
            carry         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        a_sh         <= bus.op_a;
                        b_sh         <= bus.op_b;
                        carry        <= bus.cin;
                        cnt          <= '0;
                        acc          <= '0;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    acc   <= acc_next;
                    carry <= carry_next;
                    cnt   <= cnt + 1'b1;
                    // sum/cout only update here, so they hold the last result elsewhere
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        bus.sum       <= acc_next;
                        bus.cout      <= carry_next;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
